safety_sram_responder: RTL and testbench

SAFETY_SRAM_RESPONDER -- requirements
Module: safety_sram_responder

---
 rtl/safety_sram_responder.sv | 151 +++++++++++++++
 tb/tb_safety_sram_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/safety_sram_responder.sv
// safety_sram_responder
//   Word-addressed SRAM with one even-parity bit per byte, functional parity
//   checking, and a background scrubber that walks every word once per scan.
//
//   Ports
//     clk_i, rst_n_i        clock / async active-low reset (clears the array too)
//     sram_addr_i           word address; upper bits must be zero to be in range
//     sram_wdata_i/we/wstrb write data, write enable, byte strobes
//     sram_rdata_o          combinational read data (0 when out of range)
//     par_bypass_i          writes leave stored parity untouched (fault injection)
//     check_en_i            parity check enable for functional reads
//     ecc_error_o           registered pulse on a functional parity error
//     err_addr_o            address of the latest functional error
//     err_count_o           saturating functional error count
//     addr_err_o            registered pulse for a cycle with an out-of-range address
//     scrub_start_i         starts a scan from IDLE or DONE
//     scrub_busy_o/done_o   scan in progress / last scan finished
//     scrub_err_cnt_o       saturating bad-word count of the last scan
module safety_sram_responder #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [31:0]             sram_addr_i,
  input  logic [DATA_WIDTH-1:0]   sram_wdata_i,
  input  logic                    sram_we_i,
  input  logic [DATA_WIDTH/8-1:0] sram_wstrb_i,
  output logic [DATA_WIDTH-1:0]   sram_rdata_o,
  input  logic                    par_bypass_i,
  input  logic                    check_en_i,
  output logic                    ecc_error_o,
  output logic [31:0]             err_addr_o,
  output logic [15:0]             err_count_o,
  output logic                    addr_err_o,
  input  logic                    scrub_start_i,
  output logic                    scrub_busy_o,
  output logic                    scrub_done_o,
  output logic [7:0]              scrub_err_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [NB-1:0]         par [DEPTH];

  state_t                state;
  logic [AW-1:0]         scrub_idx;

  logic [AW-1:0]         idx;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] sc_word;
  logic [NB-1:0]         wr_par, rd_calc, sc_calc;
  logic                  func_bad, scrub_bad;

  assign idx      = sram_addr_i[AW-1:0];
  assign in_range = (sram_addr_i >> AW) == 32'd0;
  assign rd_word  = mem[idx];
  // Second, independent read port for the scrubber.
  assign sc_word  = mem[scrub_idx];

  assign sram_rdata_o = in_range ? rd_word : '0;

  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign wr_par[b]  = ^sram_wdata_i[b*8 +: 8];
    assign rd_calc[b] = ^rd_word[b*8 +: 8];
    assign sc_calc[b] = ^sc_word[b*8 +: 8];
  end

  assign func_bad  = |(rd_calc ^ par[idx]);
  assign scrub_bad = |(sc_calc ^ par[scrub_idx]);

  // Array + parity. Non-blocking writes mean a scrub of the same index in the
  // same cycle still sees the pre-write word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
        par[i] <= '0;
      end
    end else if (sram_we_i && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (sram_wstrb_i[b]) begin
          mem[idx][b*8 +: 8] <= sram_wdata_i[b*8 +: 8];
          if (!par_bypass_i) par[idx][b] <= wr_par[b];
        end
      end
    end
  end

  // Functional error reporting. The address is examined every cycle, since
  // the read port is always live; an out-of-range cycle raises addr_err.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ecc_error_o <= 1'b0;
      err_addr_o  <= '0;
      err_count_o <= '0;
      addr_err_o  <= 1'b0;
    end else begin
      addr_err_o  <= !in_range;
      ecc_error_o <= 1'b0;
      if (!sram_we_i && check_en_i && in_range && func_bad) begin
        ecc_error_o <= 1'b1;
        err_addr_o  <= sram_addr_i;
        if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
      end
    end
  end

  // Scrub FSM: one word per cycle, DEPTH cycles per scan.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state           <= S_IDLE;
      scrub_idx       <= '0;
      scrub_busy_o    <= 1'b0;
      scrub_done_o    <= 1'b0;
      scrub_err_cnt_o <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (scrub_start_i) begin
            state           <= S_SCAN;
            scrub_idx       <= '0;
            scrub_err_cnt_o <= '0;
            scrub_busy_o    <= 1'b1;
            scrub_done_o    <= 1'b0;
          end
        end
        S_SCAN: begin
          if (scrub_bad && scrub_err_cnt_o != 8'hFF)
            scrub_err_cnt_o <= scrub_err_cnt_o + 8'd1;
          if (scrub_idx == AW'(DEPTH - 1)) begin
            state        <= S_DONE;
            scrub_busy_o <= 1'b0;
            scrub_done_o <= 1'b1;
          end else begin
            scrub_idx <= scrub_idx + AW'(1);
          end
        end
        default: begin
          state        <= S_IDLE;
          scrub_busy_o <= 1'b0;
          scrub_done_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_safety_sram_responder.sv
// Bench for safety_sram_responder (DEPTH=256, DATA_WIDTH=64).
// A word/parity-table model tracks what every output must be; a compare
// process checks it on each falling edge, and directed scenarios add literal
// expectations that pin the model.
module tb_safety_sram_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        we = 1'b0;
  logic [7:0]  wstrb = '0;
  logic [63:0] rdata;
  logic        byp = 1'b0;
  logic        ce = 1'b0;
  logic        ecc;
  logic [31:0] eaddr;
  logic [15:0] ecnt;
  logic        aerr;
  logic        start = 1'b0;
  logic        busy, done;
  logic [7:0]  scnt;

  int errors = 0;
  int checks = 0;

  safety_sram_responder #(.DEPTH(256), .DATA_WIDTH(64)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .sram_addr_i(addr), .sram_wdata_i(wdata),
    .sram_we_i(we), .sram_wstrb_i(wstrb), .sram_rdata_o(rdata),
    .par_bypass_i(byp), .check_en_i(ce), .ecc_error_o(ecc),
    .err_addr_o(eaddr), .err_count_o(ecnt), .addr_err_o(aerr),
    .scrub_start_i(start), .scrub_busy_o(busy), .scrub_done_o(done),
    .scrub_err_cnt_o(scnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [63:0] m_mem [256];
  logic [7:0]  m_par [256];
  logic        m_ecc, m_aerr, m_busy, m_done;
  logic [31:0] m_eaddr;
  logic [15:0] m_ecnt;
  logic [7:0]  m_scnt;
  int          m_pos;

  // A word is bad when some byte's even parity disagrees with its stored bit.
  function automatic bit bad(input int i);
    for (int b = 0; b < 8; b++)
      if ((^m_mem[i][b*8 +: 8]) != m_par[i][b]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] m_rd(input logic [31:0] a);
    return (a < 32'd256) ? m_mem[a] : 64'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        m_mem[i] <= '0;
        m_par[i] <= '0;
      end
      m_ecc <= 0; m_aerr <= 0; m_busy <= 0; m_done <= 0;
      m_eaddr <= 0; m_ecnt <= 0; m_scnt <= 0; m_pos <= 0;
    end else begin
      if (we && addr < 32'd256)
        for (int b = 0; b < 8; b++)
          if (wstrb[b]) begin
            m_mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            if (!byp) m_par[addr][b] <= ^wdata[b*8 +: 8];
          end
      m_aerr <= (addr >= 32'd256);
      m_ecc  <= 1'b0;
      if (!we && ce && addr < 32'd256 && bad(int'(addr))) begin
        m_ecc   <= 1'b1;
        m_eaddr <= addr;
        m_ecnt  <= (m_ecnt == 16'hFFFF) ? m_ecnt : m_ecnt + 16'd1;
      end
      // Scan position = number of cycles since the start; reads old contents.
      if (m_busy) begin
        if (bad(m_pos) && m_scnt != 8'hFF) m_scnt <= m_scnt + 8'd1;
        if (m_pos == 255) begin m_busy <= 0; m_done <= 1; end
        else m_pos <= m_pos + 1;
      end else if (start) begin
        m_busy <= 1; m_done <= 0; m_pos <= 0; m_scnt <= 0;
      end
    end
  end

  // ---------------- cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rdata",   rdata, m_rd(addr));
      chk("ecc",     64'(ecc), 64'(m_ecc));
      chk("erraddr", 64'(eaddr), 64'(m_eaddr));
      chk("errcnt",  64'(ecnt), 64'(m_ecnt));
      chk("addrerr", 64'(aerr), 64'(m_aerr));
      chk("busy",    64'(busy), 64'(m_busy));
      chk("done",    64'(done), 64'(m_done));
      chk("scnt",    64'(scnt), 64'(m_scnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s, input logic bp);
    addr = a; wdata = d; wstrb = s; byp = bp; we = 1; ce = 0;
    cyc();
    we = 0; byp = 0; wstrb = 0;
  endtask

  task automatic run_scan(input string name, output int n);
    n = 0;
    while (busy && n < 400) begin n++; cyc(); end
    if (n >= 400) chk({name, "_timeout"}, 64'(n), 64'd256);
  endtask

  int n;

  initial begin
    repeat (3) cyc();
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_outs", {ecc, aerr, busy, done, scnt, ecnt}, '0);
    rst_n = 1;
    cyc();

    // full-strobe write + same-cycle read
    wr(5, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0);
    addr = 5; ce = 1; #1;
    chk("rd5", rdata, 64'hDEAD_BEEF_0123_4567);
    cyc();
    chk("rd5_noecc", 64'(ecc), 64'd0);

    // bypassed write corrupts parity of addr 3
    wr(3, 64'h0, 8'hFF, 0);
    wr(3, 64'h1, 8'h01, 1);
    addr = 3; ce = 1;
    cyc();
    chk("ecc3", 64'(ecc), 64'd1);
    chk("eaddr3", 64'(eaddr), 64'd3);
    chk("ecnt3", 64'(ecnt), 64'd1);
    ce = 0;
    cyc();
    chk("ecc3_pulse", 64'(ecc), 64'd0);

    // partial strobe
    wr(7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0);
    addr = 7; #1;
    chk("rd7", rdata, 64'h0000_0000_FFFF_FFFF);

    // out of range write
    wr(32'h100, 64'h1234, 8'hFF, 0);
    chk("aerr", 64'(aerr), 64'd1);
    addr = 0; #1;
    chk("idx0_untouched", rdata, 64'd0);
    cyc();
    chk("aerr_clear", 64'(aerr), 64'd0);
    addr = 32'h100; #1;
    chk("rd_oor", rdata, 64'd0);
    cyc();
    addr = 0;
    cyc();

    // repair 3, corrupt 0 and 255, scan
    wr(3, 64'h0, 8'hFF, 0);
    wr(0, 64'h1, 8'h01, 1);
    wr(255, 64'h1, 8'h01, 1);
    addr = 0; start = 1;
    cyc();
    start = 0;
    run_scan("scan1", n);
    chk("scan1_len", 64'(n), 64'd256);
    chk("scan1_done", 64'(done), 64'd1);
    chk("scan1_cnt", 64'(scnt), 64'd2);
    chk("scan1_ecnt", 64'(ecnt), 64'd1);

    // restart; write-fix index 0 in the cycle the scan checks it (old data
    // still counts); a start pulse mid-scan is ignored
    start = 1;
    cyc();
    start = 0;
    addr = 0; wdata = 0; wstrb = 8'hFF; we = 1;
    cyc();
    we = 0; wstrb = 0; n = 1;
    repeat (10) begin n++; cyc(); end
    start = 1; cyc(); n++; start = 0;
    begin
      int m;
      run_scan("scan2", m);
      n += m;
    end
    chk("scan2_len", 64'(n), 64'd256);
    chk("scan2_cnt", 64'(scnt), 64'd2);

    // reset mid-scan at scan cycle 100
    start = 1; cyc(); start = 0;
    repeat (100) cyc();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    addr = 255; #1;
    rst_n = 0; #1;
    chk("rst_mid_outs", {ecc, aerr, busy, done, scnt, ecnt}, '0);
    chk("rst_mid_eaddr", 64'(eaddr), 64'd0);
    chk("rst_mid_rd", rdata, 64'd0);
    cyc();
    rst_n = 1; addr = 0;
    cyc();
    start = 1; cyc(); start = 0;
    run_scan("scan3", n);
    chk("scan3_done", 64'(done), 64'd1);
    chk("scan3_cnt", 64'(scnt), 64'd0);

    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
